// File: rtl/flood_pkg.sv
// Shared definitions for the colour-count / game-start front end:
// FSM state encoding, count width, default colour range and the count step rule.
package flood_pkg;

  typedef enum logic [1:0] {
    SELECT  = 2'd0,
    REQUEST = 2'd1,
    PLAYING = 2'd2
  } state_e;

  localparam int COLOR_NUM_W        = 4;
  localparam int DEF_MIN_COLORS     = 3;
  localparam int DEF_MAX_COLORS     = 8;
  localparam int DEF_DEFAULT_COLORS = 6;

  // Next colour count for one cycle of up/down pulses; opposing pulses cancel.
  function automatic logic [COLOR_NUM_W-1:0] step_count(
    input logic [COLOR_NUM_W-1:0] cur,
    input logic                   up,
    input logic                   down,
    input logic [COLOR_NUM_W-1:0] lo,
    input logic [COLOR_NUM_W-1:0] hi,
    input logic                   wrap
  );
    logic [COLOR_NUM_W-1:0] nxt;
    nxt = cur;
    if (up && !down) begin
      if (cur >= hi) nxt = wrap ? lo : hi;
      else           nxt = cur + 1'b1;
    end else if (down && !up) begin
      if (cur <= lo) nxt = wrap ? hi : lo;
      else           nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/color_count_select_if.sv
// Button / board-logic bundle for color_count_select.
// master: the board side (buttons, ACK, GAME_OVER); slave: the selector itself.
interface color_count_select_if;
  import flood_pkg::*;

  logic                   btn_up;
  logic                   btn_down;
  logic                   btn_center;
  logic                   ACK_BEGIN_GAME;
  logic                   GAME_OVER;
  logic [COLOR_NUM_W-1:0] final_COLOR_NUM;
  logic                   BEGIN_GAME;
  logic                   select_active;

  modport master (
    output btn_up, btn_down, btn_center, ACK_BEGIN_GAME, GAME_OVER,
    input  final_COLOR_NUM, BEGIN_GAME, select_active
  );

  modport slave (
    input  btn_up, btn_down, btn_center, ACK_BEGIN_GAME, GAME_OVER,
    output final_COLOR_NUM, BEGIN_GAME, select_active
  );
endinterface

// File: rtl/color_count_select_button_debounce.sv
// button_debounce: 2-FF synchronizer, stability counter and rising-edge press pulse.
// The accepted level flips only after DEBOUNCE_CYCLES consecutive samples that
// disagree with it; press is a one-cycle pulse on each accepted 0->1 change.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize, count disagreeing samples, accept the new level, and edge-detect it.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments would chain the two sync stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/color_count_select.sv
// color_count_select: debounced up/down/centre buttons drive the selectable
// colour count and the BEGIN_GAME request/ack handshake with the board logic.
// Build option: define COLOR_WRAP_EN to wrap the count at its limits instead
// of saturating.
module color_count_select
  import flood_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MIN_COLORS      = DEF_MIN_COLORS,
  parameter int MAX_COLORS      = DEF_MAX_COLORS,
  parameter int DEFAULT_COLORS  = DEF_DEFAULT_COLORS
) (
  input logic                 clk,
  input logic                 rst,
  color_count_select_if.slave bus
);

  localparam logic [COLOR_NUM_W-1:0] MIN_C = COLOR_NUM_W'(MIN_COLORS);
  localparam logic [COLOR_NUM_W-1:0] MAX_C = COLOR_NUM_W'(MAX_COLORS);
  localparam logic [COLOR_NUM_W-1:0] DEF_C = COLOR_NUM_W'(DEFAULT_COLORS);

`ifdef COLOR_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  if (MAX_COLORS > 15 || MIN_COLORS > MAX_COLORS ||
      DEFAULT_COLORS < MIN_COLORS || DEFAULT_COLORS > MAX_COLORS) begin : g_bad_cfg
    $error("color_count_select: illegal colour range parameters");
  end

  logic up_press;
  logic down_press;
  logic center_press;
  logic unused_up_level;
  logic unused_down_level;
  logic unused_center_level;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_up),
    .level(unused_up_level), .press(up_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_down),
    .level(unused_down_level), .press(down_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_center (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_center),
    .level(unused_center_level), .press(center_press)
  );

  state_e                 state_q;
  logic [COLOR_NUM_W-1:0] count_q;
  logic                   begin_q;
  logic                   active_q;

  // Game-start FSM with the count register; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SELECT;
      count_q  <= DEF_C;
      begin_q  <= 1'b0;
      active_q <= 1'b1;
    end else begin
      unique case (state_q)
        SELECT: begin
          if (center_press) begin
            state_q  <= REQUEST;
            begin_q  <= 1'b1;
            active_q <= 1'b0;
          end else begin
            count_q <= step_count(count_q, up_press, down_press, MIN_C, MAX_C, WRAP_EN);
          end
        end
        REQUEST: begin
          if (bus.ACK_BEGIN_GAME) begin
            state_q <= PLAYING;
            begin_q <= 1'b0;
          end
        end
        PLAYING: begin
          if (bus.GAME_OVER) begin
            state_q  <= SELECT;
            active_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= SELECT;
          begin_q  <= 1'b0;
          active_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.final_COLOR_NUM = count_q;
  assign bus.BEGIN_GAME      = begin_q;
  assign bus.select_active   = active_q;

endmodule

// File: tb/tb_color_count_select.sv
// Self-checking bench for color_count_select with DEBOUNCE_CYCLES=4.
// Table of clean button presses for the count path, then hand-written
// sequences for bounce, start handshake, PLAYING lockout and reset abort.
module tb_color_count_select;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  color_count_select_if bus();

  color_count_select #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

`ifdef COLOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    string    name;
    logic     up;
    logic     down;
    int       exp_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: hold long enough for one pulse, then release long enough to re-arm.
  task automatic press(input logic up, input logic down, input logic center);
    @(negedge clk);
    bus.btn_up     = up;
    bus.btn_down   = down;
    bus.btn_center = center;
    cycles(12);
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.btn_center = 1'b0;
    cycles(12);
  endtask

  task automatic wait_begin(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.BEGIN_GAME === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Independent count model: saturate or wrap in the 3..8 range.
  function automatic int model_step(input int cur, input bit up, input bit down);
    if (up && !down)   return (cur == 8) ? (WRAP ? 3 : 8) : cur + 1;
    if (down && !up)   return (cur == 3) ? (WRAP ? 8 : 3) : cur - 1;
    return cur;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  exp_cnt;
    bit  seen;
    int  drops;

    vecs[0]  = '{"up_6_to_7",     1'b1, 1'b0, 7};
    vecs[1]  = '{"up_7_to_8",     1'b1, 1'b0, 8};
    vecs[2]  = '{"up_at_max",     1'b1, 1'b0, WRAP ? 3 : 8};
    vecs[3]  = '{"down_1",        1'b0, 1'b1, WRAP ? 8 : 7};
    vecs[4]  = '{"down_2",        1'b0, 1'b1, WRAP ? 7 : 6};
    vecs[5]  = '{"down_3",        1'b0, 1'b1, WRAP ? 6 : 5};
    vecs[6]  = '{"down_4",        1'b0, 1'b1, WRAP ? 5 : 4};
    vecs[7]  = '{"down_5",        1'b0, 1'b1, WRAP ? 4 : 3};
    vecs[8]  = '{"down_6",        1'b0, 1'b1, 3};
    vecs[9]  = '{"up_and_down",   1'b1, 1'b1, 3};
    vecs[10] = '{"down_at_min",   1'b0, 1'b1, WRAP ? 8 : 3};
    vecs[11] = '{"up_after_min",  1'b1, 1'b0, WRAP ? 3 : 4};

    rst                = 1'b1;
    bus.btn_up         = 1'b0;
    bus.btn_down       = 1'b0;
    bus.btn_center     = 1'b0;
    bus.ACK_BEGIN_GAME = 1'b0;
    bus.GAME_OVER      = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    // Reset state
    check("reset_count",  int'(bus.final_COLOR_NUM), 6);
    check("reset_begin",  int'(bus.BEGIN_GAME), 0);
    check("reset_active", int'(bus.select_active), 1);

    // Count path: clean presses from the table
    foreach (vecs[i]) begin
      press(vecs[i].up, vecs[i].down, 1'b0);
      check(vecs[i].name, int'(bus.final_COLOR_NUM), vecs[i].exp_cnt);
    end
    exp_cnt = vecs[11].exp_cnt;

    // Bounce, then a long hold: exactly one increment
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.btn_up = i[0];
    end
    @(negedge clk);
    check("no_inc_during_bounce", int'(bus.final_COLOR_NUM), exp_cnt);
    bus.btn_up = 1'b1;
    cycles(30);
    bus.btn_up = 1'b0;
    cycles(12);
    exp_cnt = model_step(exp_cnt, 1'b1, 1'b0);
    check("bounce_one_inc", int'(bus.final_COLOR_NUM), exp_cnt);

    // ACK and GAME_OVER have no effect in SELECT
    @(negedge clk);
    bus.ACK_BEGIN_GAME = 1'b1;
    bus.GAME_OVER      = 1'b1;
    @(negedge clk);
    bus.ACK_BEGIN_GAME = 1'b0;
    bus.GAME_OVER      = 1'b0;
    cycles(2);
    check("select_ignores_ack", int'(bus.select_active), 1);
    check("select_no_begin",    int'(bus.BEGIN_GAME), 0);

    // Centre press: BEGIN_GAME held until ACK
    @(negedge clk);
    bus.btn_center = 1'b1;
    wait_begin(20, seen);
    check("begin_asserted",  int'(seen), 1);
    check("request_active",  int'(bus.select_active), 0);
    bus.btn_center = 1'b0;
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.BEGIN_GAME !== 1'b1) drops++;
    end
    check("begin_held_drops", drops, 0);
    bus.ACK_BEGIN_GAME = 1'b1;
    @(negedge clk);
    bus.ACK_BEGIN_GAME = 1'b0;
    check("begin_after_ack",  int'(bus.BEGIN_GAME), 0);
    check("playing_active",   int'(bus.select_active), 0);

    // PLAYING: count frozen
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("playing_count_frozen", int'(bus.final_COLOR_NUM), exp_cnt);
    check("playing_no_begin",     int'(bus.BEGIN_GAME), 0);
    @(negedge clk);
    bus.GAME_OVER = 1'b1;
    @(negedge clk);
    bus.GAME_OVER = 1'b0;
    check("gameover_active", int'(bus.select_active), 1);
    check("gameover_count",  int'(bus.final_COLOR_NUM), exp_cnt);
    press(1'b1, 1'b0, 1'b0);
    exp_cnt = model_step(exp_cnt, 1'b1, 1'b0);
    check("up_after_gameover", int'(bus.final_COLOR_NUM), exp_cnt);

    // Bring the count to 5
    for (int i = 0; i < 8 && exp_cnt != 5; i++) begin
      press(1'b0, 1'b1, 1'b0);
      exp_cnt = model_step(exp_cnt, 1'b0, 1'b1);
    end
    check("count_at_5", int'(bus.final_COLOR_NUM), 5);

    // Centre + up together: centre wins, up is discarded
    @(negedge clk);
    bus.btn_center = 1'b1;
    bus.btn_up     = 1'b1;
    wait_begin(20, seen);
    check("ctr_up_begin", int'(seen), 1);
    cycles(3);
    bus.btn_center = 1'b0;
    bus.btn_up     = 1'b0;
    cycles(12);
    check("ctr_up_count", int'(bus.final_COLOR_NUM), 5);
    check("ctr_up_still_request", int'(bus.BEGIN_GAME), 1);

    // Reset while in REQUEST aborts the request on the same edge
    rst = 1'b1;
    @(negedge clk);
    check("rst_begin",  int'(bus.BEGIN_GAME), 0);
    check("rst_count",  int'(bus.final_COLOR_NUM), 6);
    check("rst_active", int'(bus.select_active), 1);
    rst = 1'b0;
    cycles(12);
    check("post_rst_count", int'(bus.final_COLOR_NUM), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
